text_pixel_frame_fetcher: RTL and testbench

Drives the toggle-based `toggle_restart`/`toggle_next` protocol from the consumer side of `text_pixel_generator_16x4_vertical`. It walks one full 16x4-character text screen at 16 pixel rows per character, samples `cur_pixels`/`cur_char` after a fixed settle delay, and emits one write strobe per byte into a downstream pixel frame buffer. It sits between the text pixel generator and the Scroll Hat display frame logic, all in the `clk` domain.

---
 rtl/text_pixel_frame_fetcher.sv | 96 +++++++++
 tb/tb_text_pixel_frame_fetcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_frame_fetcher.sv
// Consumer-side sequencer for the 16x4 vertical text pixel generator.
// Walks one full text screen byte by byte with the restart/next toggle protocol.
// Each generator response is sampled after a fixed settle delay.
// Every sampled byte becomes one write strobe into a linear pixel frame buffer.
module text_pixel_frame_fetcher #(
  parameter int unsigned TEXT_WIDTH     = 16,
  parameter int unsigned TEXT_HEIGHT    = 4,
  parameter int unsigned CHAR_HEIGHT    = 16,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned FRAME_COUNT_SZ = 16,
  localparam int unsigned FRAME_BYTES   = TEXT_WIDTH * TEXT_HEIGHT * CHAR_HEIGHT,
  localparam int unsigned ADDR_SZ       = $clog2(FRAME_BYTES),
  localparam int unsigned SETTLE_SZ     = $clog2(SETTLE_CYCLES)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      continuous,
  output logic                      toggle_restart,
  output logic                      toggle_next,
  input  logic [7:0]                cur_char,
  input  logic [7:0]                cur_pixels,
  output logic                      pix_wr_ena,
  output logic [ADDR_SZ-1:0]        pix_wr_addr,
  output logic [7:0]                pix_wr_data,
  output logic [7:0]                pix_wr_char,
  output logic                      busy,
  output logic                      done,
  output logic [FRAME_COUNT_SZ-1:0] frame_count
);

  localparam logic [ADDR_SZ-1:0]   LastIndex  = ADDR_SZ'(FRAME_BYTES - 1);
  localparam logic [SETTLE_SZ-1:0] SettleLoad = SETTLE_SZ'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e               state;
  logic [ADDR_SZ-1:0]   index;
  logic [SETTLE_SZ-1:0] settle;

  // Frame sequencer: issues toggles, counts the settle delay, samples and writes each byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      index          <= '0;
      settle         <= '0;
      toggle_restart <= 1'b0;
      toggle_next    <= 1'b0;
      pix_wr_ena     <= 1'b0;
      pix_wr_addr    <= '0;
      pix_wr_data    <= '0;
      pix_wr_char    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      frame_count    <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      pix_wr_ena <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start || continuous) begin
            toggle_restart <= ~toggle_restart;
            index          <= '0;
            settle         <= SettleLoad;
            busy           <= 1'b1;
            state          <= StWait;
          end
        end
        StWait: begin
          if (settle != '0) begin
            settle <= settle - SETTLE_SZ'(1);
          end else begin
            pix_wr_ena  <= 1'b1;
            pix_wr_addr <= index;
            pix_wr_data <= cur_pixels;
            pix_wr_char <= cur_char;
            if (index == LastIndex) begin
              // Last byte: no next request, so the toggles never move together.
              busy        <= 1'b0;
              done        <= 1'b1;
              frame_count <= frame_count + FRAME_COUNT_SZ'(1);
              state       <= StIdle;
            end else begin
              index       <= index + ADDR_SZ'(1);
              toggle_next <= ~toggle_next;
              settle      <= SettleLoad;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_text_pixel_frame_fetcher.sv
// Directed bench for text_pixel_frame_fetcher with a small generator model.
module tb_text_pixel_frame_fetcher;

  logic        clk = 1'b0;
  logic        reset_n, start, continuous;
  logic        toggle_restart, toggle_next;
  logic [7:0]  cur_char, cur_pixels;
  logic        pix_wr_ena;
  logic [9:0]  pix_wr_addr;
  logic [7:0]  pix_wr_data, pix_wr_char;
  logic        busy, done;
  logic [15:0] frame_count;

  logic        s6_start;
  logic        s6_toggle_restart, s6_toggle_next, s6_pix_wr_ena, s6_busy, s6_done;
  logic [9:0]  s6_pix_wr_addr;
  logic [7:0]  s6_pix_wr_data, s6_pix_wr_char;
  logic [15:0] s6_frame_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  text_pixel_frame_fetcher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .toggle_restart(toggle_restart), .toggle_next(toggle_next),
    .cur_char(cur_char), .cur_pixels(cur_pixels),
    .pix_wr_ena(pix_wr_ena), .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data),
    .pix_wr_char(pix_wr_char), .busy(busy), .done(done), .frame_count(frame_count)
  );

  text_pixel_frame_fetcher #(.SETTLE_CYCLES(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .start(s6_start), .continuous(1'b0),
    .toggle_restart(s6_toggle_restart), .toggle_next(s6_toggle_next),
    .cur_char(8'h00), .cur_pixels(8'h00),
    .pix_wr_ena(s6_pix_wr_ena), .pix_wr_addr(s6_pix_wr_addr), .pix_wr_data(s6_pix_wr_data),
    .pix_wr_char(s6_pix_wr_char), .busy(s6_busy), .done(s6_done), .frame_count(s6_frame_count)
  );

  // Generator model: request counter with a 3-cycle response latency.
  logic       tr_g = 1'b0, tn_g = 1'b0;
  logic [9:0] req = '0, req_p1 = '0, req_p2 = '0;
  always @(posedge clk) begin
    if (toggle_restart !== tr_g) req <= '0;
    else if (toggle_next !== tn_g) req <= req + 10'd1;
    tr_g   <= toggle_restart;
    tn_g   <= toggle_next;
    req_p1 <= req;
    req_p2 <= req_p1;
  end
  assign cur_pixels = req_p2[7:0];
  // Text RAM: 'A' at text row 0, column 1; spaces elsewhere.
  assign cur_char   = (req_p2[9:8] == 2'd0 && req_p2[3:0] == 4'd1) ? 8'h41 : 8'h20;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the default instance, sampled on the falling edge.
  int         n_wr, n_restart, n_next, n_done, addr_err, data_err, same_err, idle_wr_err;
  int         tog_gap_err, n_gap, restart_edge, done_edge, last_tog, first_addr, exp_addr;
  int         gap [4];
  bit         done_valid;
  logic [7:0] char17, char18;
  logic       tr_m = 1'b0, tn_m = 1'b0;

  always @(negedge clk) begin
    if (pix_wr_ena) begin
      if (cyc - last_tog != 4) tog_gap_err++;
      if (done_valid && cyc == done_edge + 1) idle_wr_err++;
    end
    if (toggle_restart !== tr_m && toggle_next !== tn_m) same_err++;
    if (toggle_restart !== tr_m) begin
      n_restart++;
      restart_edge = cyc;
      last_tog     = cyc;
      exp_addr     = 0;
      if (done_valid && n_gap < 4) begin
        gap[n_gap] = cyc - done_edge;
        n_gap++;
      end
    end
    if (toggle_next !== tn_m) begin
      n_next++;
      last_tog = cyc;
    end
    tr_m = toggle_restart;
    tn_m = toggle_next;
    if (done) begin
      n_done++;
      done_edge  = cyc;
      done_valid = 1'b1;
    end
    if (pix_wr_ena) begin
      if (n_wr == 0) first_addr = int'(pix_wr_addr);
      if (int'(pix_wr_addr) != exp_addr) addr_err++;
      if (pix_wr_data !== exp_addr[7:0]) data_err++;
      if (pix_wr_addr == 10'd17) char17 = pix_wr_char;
      if (pix_wr_addr == 10'd18) char18 = pix_wr_char;
      exp_addr++;
      n_wr++;
    end
  end

  // Monitor for the SETTLE_CYCLES=6 instance.
  int   s6_restart_edge, s6_first_next, s6_first_wr, s6_done_edge, s6_n_next, s6_n_wr;
  int   s6_last_tog, s6_gap_err;
  logic s6_tr_m = 1'b0, s6_tn_m = 1'b0;

  always @(negedge clk) begin
    if (s6_pix_wr_ena) begin
      if (cyc - s6_last_tog != 6) s6_gap_err++;
      if (s6_n_wr == 0) s6_first_wr = cyc;
      s6_n_wr++;
    end
    if (s6_toggle_restart !== s6_tr_m) begin
      s6_restart_edge = cyc;
      s6_last_tog     = cyc;
    end
    if (s6_toggle_next !== s6_tn_m) begin
      if (s6_n_next == 0) s6_first_next = cyc;
      s6_n_next++;
      s6_last_tog = cyc;
    end
    s6_tr_m = s6_toggle_restart;
    s6_tn_m = s6_toggle_next;
    if (s6_done) s6_done_edge = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_wr = 0; n_restart = 0; n_next = 0; n_done = 0; addr_err = 0; data_err = 0;
    same_err = 0; idle_wr_err = 0; tog_gap_err = 0; n_gap = 0; exp_addr = 0;
    done_valid = 1'b0; first_addr = -1; char17 = 8'hxx; char18 = 8'hxx;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_toggles"}, {30'd0, toggle_restart, toggle_next}, 32'd0);
    check({tag, "_ena_busy_done"}, {29'd0, pix_wr_ena, busy, done}, 32'd0);
    check({tag, "_wr_fields"}, {6'd0, pix_wr_addr, pix_wr_data, pix_wr_char}, 32'd0);
    check({tag, "_frame_count"}, frame_count, 32'd0);
  endtask

  bit ok;

  initial begin
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0; s6_start = 1'b0;
    s6_n_next = 0; s6_n_wr = 0; s6_gap_err = 0;
    s6_first_next = -1; s6_first_wr = -1; s6_restart_edge = 0; s6_done_edge = 0;
    last_tog = 0; s6_last_tog = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single frame; start held high well into the frame must not restart it.
    clear_mon();
    start = 1'b1;
    repeat (100) @(negedge clk);
    check("busy_during_frame", busy, 1);
    start = 1'b0;
    wait_done(5000, ok);
    check("frame1_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    check("frame1_strobes", n_wr, 1024);
    check("frame1_addr_order", addr_err, 0);
    check("frame1_data", data_err, 0);
    check("frame1_restarts", n_restart, 1);
    check("frame1_nexts", n_next, 1023);
    check("frame1_done_count", n_done, 1);
    check("frame1_done_latency", done_edge - restart_edge, 4096);
    check("frame1_sample_spacing", tog_gap_err, 0);
    check("frame1_toggles_apart", same_err, 0);
    check("frame1_char_addr17", char17, 8'h41);
    check("frame1_char_addr18", char18, 8'h20);
    check("frame1_count", frame_count, 1);
    check("frame1_busy_low", busy, 0);

    // Reset during byte 300, then a fresh start.
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && n_wr < 301; i++) @(negedge clk);
    check("midreset_reached_byte300", n_wr, 301);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    repeat (50) @(negedge clk);
    check("midreset_no_strobes", n_wr, 0);
    check("midreset_no_done", n_done, 0);
    check("midreset_idle", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && n_wr == 0; i++) @(negedge clk);
    check("restart_first_addr", first_addr, 0);
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Three back-to-back continuous frames.
    clear_mon();
    continuous = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      wait_done(5000, ok);
      check("cont_done_seen", ok, 1);
      check("cont_frame_count", frame_count, f);
      if (f == 3) continuous = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("cont_restarts", n_restart, 3);
    check("cont_gap_count", n_gap, 2);
    check("cont_gap0", gap[0], 1);
    check("cont_gap1", gap[1], 1);
    check("cont_idle_strobes", idle_wr_err, 0);
    check("cont_strobes", n_wr, 3072);
    check("cont_addr_order", addr_err, 0);
    check("cont_data", data_err, 0);
    check("cont_stopped", busy, 0);

    // SETTLE_CYCLES=6 instance.
    s6_start = 1'b1;
    @(negedge clk);
    s6_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (s6_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("s6_done_seen", ok, 1);
    @(negedge clk);
    check("s6_first_next", s6_first_next - s6_restart_edge, 6);
    check("s6_first_sample", s6_first_wr - s6_restart_edge, 6);
    check("s6_sample_spacing", s6_gap_err, 0);
    check("s6_frame_length", s6_done_edge - s6_restart_edge, 6144);
    check("s6_strobes", s6_n_wr, 1024);
    check("s6_nexts", s6_n_next, 1023);
    check("s6_frame_count", s6_frame_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
